// File: rtl/alu_multicycle.sv
// alu_multicycle: single-issue ALU with one-cycle ops and a bit-serial arithmetic right shift
module alu_multicycle (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [4:0]  shamt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [3:0] OP_SRA = 4'b1001;
  state_t      state;
  logic [31:0] sh_q;
  logic [4:0]  cnt;
  logic [31:0] alu;
  logic [31:0] sh_nxt;
  logic        ill;
  logic        go_shift;
  always_comb begin
    alu = ctrl_i == 4'b0000 ? src1_i & src2_i :
          ctrl_i == 4'b0001 ? src1_i | src2_i :
          ctrl_i == 4'b0010 ? src1_i + src2_i :
          ctrl_i == 4'b0110 ? src1_i - src2_i :
          ctrl_i == 4'b0111 ? {31'd0, src1_i < src2_i} :
          ctrl_i == 4'b1000 ? {31'd0, $signed(src1_i) < $signed(src2_i)} :
          ctrl_i == OP_SRA  ? src2_i :
          ctrl_i == 4'b1011 ? {src2_i[15:0], 16'h0000} : 32'd0;
    ill = !(ctrl_i inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, OP_SRA, 4'b1011});
    sh_nxt = {sh_q[31], sh_q[31:1]};
    go_shift = ctrl_i == OP_SRA && shamt_i != 5'd0;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      sh_q     <= 32'd0;
      cnt      <= 5'd0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= 32'd0;
      zero_o   <= 1'b1;
      err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          busy_o <= 1'b1;
          if (go_shift) begin
            sh_q  <= src2_i;
            cnt   <= shamt_i;
            state <= SHIFT;
          end else begin
            result_o <= alu;
            zero_o   <= alu == 32'd0;
            err_o    <= ill;
            done_o   <= 1'b1;
            state    <= DONE;
          end
        end
        SHIFT: begin
          sh_q <= sh_nxt;
          cnt  <= cnt - 5'd1;
          // the last shift lands directly in the result register
          if (cnt == 5'd1) begin
            result_o <= sh_nxt;
            zero_o   <= sh_nxt == 32'd0;
            err_o    <= 1'b0;
            done_o   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random checks of alu_multicycle against an arithmetic model
module tb_alu_multicycle;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  ctrl_i = 4'd0;
  logic [31:0] src1_i = 32'd0;
  logic [31:0] src2_i = 32'd0;
  logic [4:0]  shamt_i = 5'd0;
  logic        busy_o, done_o, zero_o, err_o;
  logic [31:0] result_o;
  int total = 0;
  int bad = 0;

  alu_multicycle dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ctrl_i(ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .shamt_i(shamt_i), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o), .zero_o(zero_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: r = $signed(b) >>> s;
      4'b1011: r = b << 16;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    logic [32:0] m;
    int n;
    int lat;
    m = model(c, a, b, s);
    lat = (c == 4'b1001) ? 1 + s : 1;
    @(negedge clk_i);
    ctrl_i = c; src1_i = a; src2_i = b; shamt_i = s; start_i = 1'b1;
    @(negedge clk_i);
    n = 1;
    start_i = 1'b0;
    ctrl_i = 4'($urandom); src1_i = $urandom; src2_i = $urandom; shamt_i = 5'($urandom);
    while (!done_o && n < 100) begin
      chk("busy_in_flight", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      n++;
      start_i = 1'($urandom);
      ctrl_i = 4'b0010; src1_i = $urandom; src2_i = $urandom;
    end
    start_i = 1'b0;
    chk("latency", n, lat);
    chk("busy_at_done", 32'(busy_o), 32'd1);
    chk("result", result_o, m[31:0]);
    chk("zero", 32'(zero_o), 32'(m[31:0] == 32'd0));
    chk("err", 32'(err_o), 32'(m[32]));
    @(negedge clk_i);
    chk("done_one_pulse", 32'(done_o), 32'd0);
    chk("busy_after", 32'(busy_o), 32'd0);
    chk("result_hold", result_o, m[31:0]);
  endtask

  initial begin
    logic [3:0] c;
    logic [4:0] s;
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd1;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd1);
    chk("rst_err", 32'(err_o), 32'd0);
    start_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("idle_busy", 32'(busy_o), 32'd0);
    run_op(4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0);
    run_op(4'b1000, 32'hFFFFFFFF, 32'd1, 5'd0);
    run_op(4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0);
    run_op(4'b0110, 32'd5, 32'd5, 5'd0);
    run_op(4'b1001, 32'd0, 32'h80000000, 5'd4);
    run_op(4'b1001, 32'd0, 32'h80000000, 5'd0);
    run_op(4'b1001, 32'd0, 32'h80000000, 5'd31);
    run_op(4'b1001, 32'd0, 32'h7FFFFFFF, 5'd31);
    run_op(4'b1001, 32'd0, 32'h80000000, 5'd8);
    run_op(4'b1011, 32'd0, 32'h0000ABCD, 5'd0);
    run_op(4'b1111, 32'd3, 32'd4, 5'd0);
    run_op(4'b0110, 32'd0, 32'd1, 5'd0);
    // abort an SRA two cycles in; reset must clear outputs without a clock edge
    @(negedge clk_i);
    ctrl_i = 4'b1001; src2_i = 32'h80000000; shamt_i = 5'd10; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_result", result_o, 32'd0);
    chk("abort_zero", 32'(zero_o), 32'd1);
    chk("abort_err", 32'(err_o), 32'd0);
    start_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("abort_hold_busy", 32'(busy_o), 32'd0);
    start_i = 1'b0;
    rst_i = 1'b1;
    repeat (12) begin
      @(negedge clk_i);
      chk("abort_no_done", 32'(done_o), 32'd0);
    end
    run_op(4'b0010, 32'd40, 32'd2, 5'd0);
    for (int i = 0; i < 150; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 4'b1001 : 4'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1) * 31) : 5'($urandom);
      run_op(c, $urandom, $urandom, s);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
